fma_addsub_seq: RTL and testbench

Multi-cycle controller that sequences the FMA's shared 48-bit conditional inverter and adder to combine the product magnitude with the aligned addend magnitude in sign-magnitude form. It decides effective add vs. effective subtract, drives the inverter control and carry-in, and re-complements a negative intermediate. It sits between the multiplier/alignment stage and the normalizer, with valid/ready handshakes on both sides.

---
 rtl/fma_pkg.sv | 14 +
 rtl/inverter.sv | 16 +
 rtl/fma_addsub_seq.sv | 138 +++++++++++++
 tb/tb_fma_addsub_seq.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/fma_pkg.sv
// Shared FMA definitions: magnitude width and
// the add/sub sequencer state encoding.
package fma_pkg;

  localparam int FMA_MAG_W = 48;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } fma_seq_state_t;

endpackage

// File: rtl/inverter.sv
// Conditional one's-complement inverter shared
// by the FMA magnitude datapath.
module inverter
  import fma_pkg::*;
#(
  parameter int WIDTH = FMA_MAG_W
) (
  input  logic             control,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);

  // Invert every bit when control is set
  assign out = control ? ~in : in;

endmodule

// File: rtl/fma_addsub_seq.sv
// Sign-magnitude add/sub sequencer: one shared
// inverter+adder pass per cycle, FIX recomplements.
module fma_addsub_seq
  import fma_pkg::*;
#(
  parameter int WIDTH = FMA_MAG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sign_p,
  input  logic [WIDTH-1:0] mag_p,
  input  logic             sign_c,
  input  logic [WIDTH-1:0] mag_c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             res_sign,
  output logic [WIDTH-1:0] res_mag,
  output logic             res_ovf,
  output logic             res_zero,
  output logic             busy
);

  fma_seq_state_t   r_state;
  logic             r_sign_p;
  logic             r_sign_c;
  logic [WIDTH-1:0] r_mag_p;
  logic [WIDTH-1:0] r_mag_c;
  logic [WIDTH-1:0] r_acc;
  logic             r_eff_sub;
  logic             r_out_valid;
  logic             r_res_sign;
  logic [WIDTH-1:0] r_res_mag;
  logic             r_res_ovf;
  logic             r_res_zero;
  logic             r_busy;

  logic             w_fix;
  logic             w_inv_ctrl;
  logic [WIDTH-1:0] w_inv_in;
  logic [WIDTH-1:0] w_inv_out;
  logic [WIDTH-1:0] w_add_a;
  logic [WIDTH:0]   w_sum;
  logic             w_co;
  logic             w_zero;

  // Shared datapath: FIX negates acc as 0 + ~acc + 1
  assign w_fix      = (r_state == FIX);
  assign w_inv_ctrl = w_fix | r_eff_sub;
  assign w_inv_in   = w_fix ? r_acc : r_mag_c;
  assign w_add_a    = w_fix ? '0 : r_mag_p;

  inverter #(
    .WIDTH(WIDTH)
  ) u_inv (
    .control(w_inv_ctrl),
    .in     (w_inv_in),
    .out    (w_inv_out)
  );

  assign w_sum  = {1'b0, w_add_a}
                + {1'b0, w_inv_out}
                + {{WIDTH{1'b0}}, w_inv_ctrl};
  assign w_co   = w_sum[WIDTH];
  assign w_zero = (w_sum[WIDTH-1:0] == '0);

  assign in_ready  = rst_n & (r_state == IDLE);
  assign out_valid = r_out_valid;
  assign res_sign  = r_res_sign;
  assign res_mag   = r_res_mag;
  assign res_ovf   = r_res_ovf;
  assign res_zero  = r_res_zero;
  assign busy      = r_busy;

  // Sequencer FSM with registered result outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_sign_p    <= 1'b0;
      r_sign_c    <= 1'b0;
      r_mag_p     <= '0;
      r_mag_c     <= '0;
      r_acc       <= '0;
      r_eff_sub   <= 1'b0;
      r_out_valid <= 1'b0;
      r_res_sign  <= 1'b0;
      r_res_mag   <= '0;
      r_res_ovf   <= 1'b0;
      r_res_zero  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_sign_p  <= sign_p;
            r_sign_c  <= sign_c;
            r_mag_p   <= mag_p;
            r_mag_c   <= mag_c;
            r_eff_sub <= sign_p ^ sign_c;
            r_busy    <= 1'b1;
            r_state   <= ADD;
          end
        end
        ADD: begin
          if (!r_eff_sub || w_co) begin
            r_res_mag   <= w_sum[WIDTH-1:0];
            r_res_ovf   <= ~r_eff_sub & w_co;
            r_res_sign  <= r_sign_p & ~(r_eff_sub & w_zero);
            r_res_zero  <= w_zero;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_acc   <= w_sum[WIDTH-1:0];
            r_state <= FIX;
          end
        end
        FIX: begin
          r_res_mag   <= w_sum[WIDTH-1:0];
          r_res_ovf   <= 1'b0;
          r_res_sign  <= r_sign_c;
          r_res_zero  <= w_zero;
          r_out_valid <= 1'b1;
          r_state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fma_addsub_seq.sv
// Directed bench for fma_addsub_seq: vector table
// plus stall and mid-FIX reset sequences.
module tb_fma_addsub_seq;

  localparam int W = 48;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic         sign_p;
  logic [W-1:0] mag_p;
  logic         sign_c;
  logic [W-1:0] mag_c;
  logic         out_valid;
  logic         out_ready;
  logic         res_sign;
  logic [W-1:0] res_mag;
  logic         res_ovf;
  logic         res_zero;
  logic         busy;

  int checks;
  int errors;

  fma_addsub_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .sign_p   (sign_p),
    .mag_p    (mag_p),
    .sign_c   (sign_c),
    .mag_c    (mag_c),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .res_sign (res_sign),
    .res_mag  (res_mag),
    .res_ovf  (res_ovf),
    .res_zero (res_zero),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         sp;
    logic [W-1:0] mp;
    logic         sc;
    logic [W-1:0] mc;
    logic         e_sign;
    logic [W-1:0] e_mag;
    logic         e_ovf;
    logic         e_zero;
    int           e_lat;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // Present one operand set, return edges to out_valid
  task automatic issue(input logic sp,
                       input logic [W-1:0] mp,
                       input logic sc,
                       input logic [W-1:0] mc,
                       output int lat);
    @(negedge clk);
    sign_p   = sp;
    mag_p    = mp;
    sign_c   = sc;
    mag_c    = mc;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (lat < 10) begin
      @(posedge clk);
      lat++;
      #1;
      if (out_valid) break;
    end
  endtask

  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("ovalid_clr", 64'(out_valid), 64'd0);
    chk("iready_idle", 64'(in_ready), 64'd1);
  endtask

  initial begin
    int lat;
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    sign_p    = 1'b0;
    sign_c    = 1'b0;
    mag_p     = '0;
    mag_c     = '0;

    vt[0] = '{0, 48'd100, 0, 48'd23,
              0, 48'd123, 0, 0, 1};
    vt[1] = '{0, 48'd100, 1, 48'd23,
              0, 48'd77, 0, 0, 1};
    vt[2] = '{0, 48'd23, 1, 48'd100,
              1, 48'd77, 0, 0, 2};
    vt[3] = '{1, 48'd5, 0, 48'd5,
              0, 48'd0, 0, 1, 1};
    vt[4] = '{0, 48'hFFFF_FFFF_FFFF,
              0, 48'hFFFF_FFFF_FFFF,
              0, 48'hFFFF_FFFF_FFFE, 1, 0, 1};
    vt[5] = '{1, 48'd0, 1, 48'd7,
              1, 48'd7, 0, 0, 1};
    vt[6] = '{1, 48'd10, 0, 48'd300,
              0, 48'd290, 0, 0, 2};
    vt[7] = '{0, 48'd0, 1, 48'd1,
              1, 48'd1, 0, 0, 2};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_iready", 64'(in_ready), 64'd0);
    chk("rst_ovalid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_mag", 64'(res_mag), 64'd0);
    chk("rst_sign", 64'(res_sign), 64'd0);
    chk("rst_ovf", 64'(res_ovf), 64'd0);
    chk("rst_zero", 64'(res_zero), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_iready", 64'(in_ready), 64'd1);

    // Vector table
    foreach (vt[i]) begin
      issue(vt[i].sp, vt[i].mp,
            vt[i].sc, vt[i].mc, lat);
      chk($sformatf("v%0d_lat", i),
          64'(lat), 64'(vt[i].e_lat));
      chk($sformatf("v%0d_mag", i),
          64'(res_mag), 64'(vt[i].e_mag));
      chk($sformatf("v%0d_sign", i),
          64'(res_sign), 64'(vt[i].e_sign));
      chk($sformatf("v%0d_ovf", i),
          64'(res_ovf), 64'(vt[i].e_ovf));
      chk($sformatf("v%0d_zero", i),
          64'(res_zero), 64'(vt[i].e_zero));
      chk($sformatf("v%0d_busy", i),
          64'(busy), 64'd1);
      chk($sformatf("v%0d_iready", i),
          64'(in_ready), 64'd0);
      release_out();
    end

    // Stall in DONE for 5 cycles with in_valid noise
    issue(0, 48'd23, 1, 48'd100, lat);
    chk("stall_lat", 64'(lat), 64'd2);
    @(negedge clk);
    in_valid = 1'b1;
    sign_p   = 1'b0;
    mag_p    = 48'd999;
    sign_c   = 1'b0;
    mag_c    = 48'd1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk("stall_ovalid", 64'(out_valid), 64'd1);
      chk("stall_mag", 64'(res_mag), 64'd77);
      chk("stall_sign", 64'(res_sign), 64'd1);
      chk("stall_iready", 64'(in_ready), 64'd0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    release_out();
    @(posedge clk);
    #1;
    chk("noise_not_taken", 64'(busy), 64'd0);

    // Reset asserted while in FIX
    @(negedge clk);
    sign_p   = 1'b0;
    mag_p    = 48'd23;
    sign_c   = 1'b1;
    mag_c    = 48'd100;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("fix_busy", 64'(busy), 64'd1);
    chk("fix_ovalid", 64'(out_valid), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("fixrst_iready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    chk("fixrst_ovalid", 64'(out_valid), 64'd0);
    chk("fixrst_busy", 64'(busy), 64'd0);
    chk("fixrst_mag", 64'(res_mag), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("fixrst_iready_rel", 64'(in_ready), 64'd1);

    // Operation resumes cleanly after reset
    issue(0, 48'd100, 0, 48'd23, lat);
    chk("post_lat", 64'(lat), 64'd1);
    chk("post_mag", 64'(res_mag), 64'd123);
    release_out();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
